// File: rtl/compound_arbiter.sv
// ============================================================================
// Module   : compound_arbiter
// Brief    : Two-requester arbiter feeding one CompoundType channel, with
//            write priority, starvation guard and a transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package compound_arbiter_pkg;
    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_t;

    typedef struct packed {
        mode_t      mode;
        logic [7:0] x;
        logic [7:0] y;
    } CompoundType;
endpackage

module compound_arbiter
    import compound_arbiter_pkg::*;
#(
    parameter int PRIO_WRITE = 1,
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  CompoundType       a_in,
    input  logic              a_in_sync,
    output logic              a_in_notify,
    input  CompoundType       b_in,
    input  logic              b_in_sync,
    output logic              b_in_notify,
    output CompoundType       m_out,
    input  logic              m_out_sync,
    output logic              m_out_notify,
    output logic              grant_id,
    output logic [CNT_W-1:0]  xfer_count
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [3:0] c_STARVE_SAT = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             r_state,        w_state_nxt;
    logic               r_a_notify,     w_a_notify_nxt;
    logic               r_b_notify,     w_b_notify_nxt;
    logic               r_m_notify,     w_m_notify_nxt;
    CompoundType        r_m_out,        w_m_out_nxt;
    logic               r_grant_id,     w_grant_id_nxt;
    logic               r_last_grant,   w_last_grant_nxt;
    logic [3:0]         r_starve_a,     w_starve_a_nxt;
    logic [3:0]         r_starve_b,     w_starve_b_nxt;
    logic [CNT_W-1:0]   r_xfer_count,   w_xfer_count_nxt;

    logic               w_contested;
    logic               w_win_b;

    assign w_contested = a_in_sync & b_in_sync;

    // Winner selection; only meaningful while at least one sync is high.
    always_comb begin
        w_win_b = b_in_sync;
        if (w_contested) begin
            if (r_starve_a >= c_STARVE_MAX) begin
                w_win_b = 1'b0;
            end else if (r_starve_b >= c_STARVE_MAX) begin
                w_win_b = 1'b1;
            end else if ((PRIO_WRITE != 0) && (a_in.mode != b_in.mode)) begin
                w_win_b = (b_in.mode == MODE_WRITE);
            end else begin
                w_win_b = ~r_last_grant;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_a_notify_nxt   = 1'b0;
        w_b_notify_nxt   = 1'b0;
        w_m_notify_nxt   = r_m_notify;
        w_m_out_nxt      = r_m_out;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_starve_a_nxt   = r_starve_a;
        w_starve_b_nxt   = r_starve_b;
        w_xfer_count_nxt = r_xfer_count;

        case (r_state)
            ST_IDLE: begin
                if (a_in_sync | b_in_sync) begin
                    w_state_nxt      = ST_SEND;
                    w_m_out_nxt      = w_win_b ? b_in : a_in;
                    w_grant_id_nxt   = w_win_b;
                    w_last_grant_nxt = w_win_b;
                    w_a_notify_nxt   = ~w_win_b;
                    w_b_notify_nxt   = w_win_b;
                    w_m_notify_nxt   = 1'b1;
                    if (w_win_b) begin
                        w_starve_b_nxt = 4'd0;
                        if (w_contested && (r_starve_a != c_STARVE_SAT)) begin
                            w_starve_a_nxt = r_starve_a + 4'd1;
                        end
                    end else begin
                        w_starve_a_nxt = 4'd0;
                        if (w_contested && (r_starve_b != c_STARVE_SAT)) begin
                            w_starve_b_nxt = r_starve_b + 4'd1;
                        end
                    end
                end
            end
            ST_SEND: begin
                if (m_out_sync) begin
                    w_state_nxt      = ST_IDLE;
                    w_m_notify_nxt   = 1'b0;
                    w_xfer_count_nxt = r_xfer_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // last_grant resets to B so that A wins the first round-robin tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_a_notify   <= 1'b0;
            r_b_notify   <= 1'b0;
            r_m_notify   <= 1'b0;
            r_m_out      <= '{mode: MODE_READ, x: 8'd0, y: 8'd0};
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_starve_a   <= 4'd0;
            r_starve_b   <= 4'd0;
            r_xfer_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_a_notify   <= w_a_notify_nxt;
            r_b_notify   <= w_b_notify_nxt;
            r_m_notify   <= w_m_notify_nxt;
            r_m_out      <= w_m_out_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_starve_a   <= w_starve_a_nxt;
            r_starve_b   <= w_starve_b_nxt;
            r_xfer_count <= w_xfer_count_nxt;
        end
    end

    assign a_in_notify  = r_a_notify;
    assign b_in_notify  = r_b_notify;
    assign m_out_notify = r_m_notify;
    assign m_out        = r_m_out;
    assign grant_id     = r_grant_id;
    assign xfer_count   = r_xfer_count;

endmodule

`default_nettype wire

// File: tb/tb_compound_arbiter.sv
// ============================================================================
// Module   : tb_compound_arbiter
// Brief    : Bench for compound_arbiter; two parameterisations checked against
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compound_arbiter;
    import compound_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    CompoundType a_in[2], b_in[2], m_out[2];
    logic        a_sync[2], b_sync[2], o_sync[2];
    logic        a_ntf[2], b_ntf[2], m_ntf[2], gid[2];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    compound_arbiter #(.PRIO_WRITE(1), .STARVE_MAX(3), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst),
        .a_in(a_in[0]), .a_in_sync(a_sync[0]), .a_in_notify(a_ntf[0]),
        .b_in(b_in[0]), .b_in_sync(b_sync[0]), .b_in_notify(b_ntf[0]),
        .m_out(m_out[0]), .m_out_sync(o_sync[0]), .m_out_notify(m_ntf[0]),
        .grant_id(gid[0]), .xfer_count(cnt0)
    );

    compound_arbiter #(.PRIO_WRITE(0), .STARVE_MAX(2), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_in(a_in[1]), .a_in_sync(a_sync[1]), .a_in_notify(a_ntf[1]),
        .b_in(b_in[1]), .b_in_sync(b_sync[1]), .b_in_notify(b_ntf[1]),
        .m_out(m_out[1]), .m_out_sync(o_sync[1]), .m_out_notify(m_ntf[1]),
        .grant_id(gid[1]), .xfer_count(cnt1)
    );

    // Reference model state, one slot per DUT
    int          c_pw[2] = '{1, 0};
    int          c_sm[2] = '{3, 2};
    int          c_cw[2] = '{16, 4};
    bit          e_busy[2], e_an[2], e_bn[2], e_mn[2], e_gid[2], e_last[2];
    int          e_sa[2], e_sb[2], e_cnt[2];
    CompoundType e_msg[2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic CompoundType rand_msg();
        CompoundType m;
        m.mode = mode_t'($urandom_range(0, 1));
        m.x    = 8'($urandom);
        m.y    = 8'($urandom);
        return m;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_busy[d] = 0; e_an[d] = 0; e_bn[d] = 0; e_mn[d] = 0;
            e_gid[d]  = 0; e_last[d] = 1; e_sa[d] = 0; e_sb[d] = 0;
            e_cnt[d]  = 0; e_msg[d] = '0;
        end
    endtask

    // Predicts the DUT outputs after the next rising edge from the current inputs
    task automatic model_step(input int d);
        bit w;
        e_an[d] = 0;
        e_bn[d] = 0;
        if (e_busy[d]) begin
            if (o_sync[d]) begin
                e_busy[d] = 0;
                e_mn[d]   = 0;
                e_cnt[d]  = (e_cnt[d] + 1) % (1 << c_cw[d]);
            end
        end else if (a_sync[d] || b_sync[d]) begin
            if (a_sync[d] && b_sync[d]) begin
                if (e_sa[d] >= c_sm[d])      w = 0;
                else if (e_sb[d] >= c_sm[d]) w = 1;
                else if (c_pw[d] != 0 && a_in[d].mode != b_in[d].mode)
                    w = (b_in[d].mode == MODE_WRITE);
                else                         w = !e_last[d];
                if (w) e_sa[d] = (e_sa[d] < 15) ? e_sa[d] + 1 : 15;
                else   e_sb[d] = (e_sb[d] < 15) ? e_sb[d] + 1 : 15;
            end else begin
                w = b_sync[d];
            end
            if (w) e_sb[d] = 0; else e_sa[d] = 0;
            e_msg[d]  = w ? b_in[d] : a_in[d];
            e_gid[d]  = w;
            e_last[d] = w;
            e_an[d]   = !w;
            e_bn[d]   = w;
            e_mn[d]   = 1;
            e_busy[d] = 1;
        end
    endtask

    task automatic compare_all(input int d);
        check($sformatf("d%0d a_in_notify", d),  32'(a_ntf[d]), 32'(e_an[d]));
        check($sformatf("d%0d b_in_notify", d),  32'(b_ntf[d]), 32'(e_bn[d]));
        check($sformatf("d%0d m_out_notify", d), 32'(m_ntf[d]), 32'(e_mn[d]));
        check($sformatf("d%0d grant_id", d),     32'(gid[d]),   32'(e_gid[d]));
        check($sformatf("d%0d m_out", d),        {15'd0, m_out[d]}, {15'd0, e_msg[d]});
        check($sformatf("d%0d xfer_count", d),
              (d == 0) ? 32'(cnt0) : 32'(cnt1), 32'(e_cnt[d]));
    endtask

    // mode 0: random traffic; 1: A always write, B always read; 2: A only, writes
    task automatic drive(input int d, input int mode);
        if (mode == 0) begin
            if (!a_sync[d] || a_ntf[d]) begin
                a_sync[d] = ($urandom_range(0, 3) != 0);
                a_in[d]   = rand_msg();
            end
            if (!b_sync[d] || b_ntf[d]) begin
                b_sync[d] = ($urandom_range(0, 3) != 0);
                b_in[d]   = rand_msg();
            end
            o_sync[d] = ($urandom_range(0, 1) == 1);
        end else begin
            if (!a_sync[d] || a_ntf[d]) a_in[d] = rand_msg();
            a_in[d].mode = MODE_WRITE;
            a_sync[d]    = 1'b1;
            if (mode == 1) begin
                if (!b_sync[d] || b_ntf[d]) b_in[d] = rand_msg();
                b_in[d].mode = MODE_READ;
                b_sync[d]    = 1'b1;
            end else begin
                b_sync[d] = 1'b0;
            end
            o_sync[d] = 1'b1;
        end
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) model_step(d);
        @(negedge clk);
        for (int d = 0; d < 2; d++) compare_all(d);
    endtask

    // Asynchronous assertion is checked before any clock edge arrives
    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) compare_all(d);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int q0[$], q1[$];
    int exp0[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int exp1[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int ntf_cnt[2];

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            a_in[d] = '0; b_in[d] = '0;
            a_sync[d] = 1'b0; b_sync[d] = 1'b0; o_sync[d] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) compare_all(d);
        rst = 1'b0;

        // Single uncontested transfer with the consumer already ready
        for (int d = 0; d < 2; d++) begin
            a_sync[d] = 1'b1;
            a_in[d]   = '{mode: MODE_WRITE, x: 8'd5, y: 8'd1};
            b_sync[d] = 1'b0;
            o_sync[d] = 1'b1;
        end
        step();
        check("single ack",   32'(a_ntf[0]), 32'd1);
        check("single m_out", {15'd0, m_out[0]}, {15'd0, 1'b1, 8'd5, 8'd1});
        check("single grant", 32'(gid[0]), 32'd0);
        for (int d = 0; d < 2; d++) a_sync[d] = 1'b0;
        step();
        check("single m_out_notify", 32'(m_ntf[0]), 32'd0);
        check("single count",        32'(cnt0), 32'd1);

        // Write priority with starvation relief (dut0) and round-robin (dut1)
        reset_pulse();
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 2; d++) drive(d, 1);
            step();
            if (a_ntf[0] || b_ntf[0]) q0.push_back(int'(gid[0]));
            if (a_ntf[1] || b_ntf[1]) q1.push_back(int'(gid[1]));
        end
        check("prio grant count", 32'(q0.size()), 32'd8);
        check("rr grant count",   32'(q1.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("prio grant %0d", i), 32'((i < q0.size()) ? q0[i] : 99), 32'(exp0[i]));
            check($sformatf("rr grant %0d", i),   32'((i < q1.size()) ? q1[i] : 99), 32'(exp1[i]));
        end

        // Backpressure: one grant, then the consumer stalls for ten cycles
        reset_pulse();
        for (int d = 0; d < 2; d++) ntf_cnt[d] = 0;
        for (int i = 0; i < 11; i++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, 1);
                o_sync[d] = 1'b0;
            end
            step();
            for (int d = 0; d < 2; d++) ntf_cnt[d] += int'(a_ntf[d]) + int'(b_ntf[d]);
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d stall ack count", d), 32'(ntf_cnt[d]), 32'd1);
            check($sformatf("d%0d stall notify", d),    32'(m_ntf[d]), 32'd1);
            drive(d, 1);
        end
        step();
        check("release count d0", 32'(cnt0), 32'd1);
        check("release count d1", 32'(cnt1), 32'd1);

        // Reset while a message is pending downstream
        for (int d = 0; d < 2; d++) begin
            drive(d, 1);
            o_sync[d] = 1'b0;
        end
        step();
        reset_pulse();

        // Sixteen back-to-back transfers wrap the 4-bit counter
        for (int i = 0; i < 32; i++) begin
            for (int d = 0; d < 2; d++) drive(d, 2);
            step();
        end
        check("wrap count d1", 32'(cnt1), 32'd0);
        check("wrap count d0", 32'(cnt0), 32'd16);

        // Random traffic with occasional resets
        reset_pulse();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse();
            end else begin
                for (int d = 0; d < 2; d++) drive(d, 0);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
